// File: rtl/pipe_elastic_stage.sv
// rtl/pipe_elastic_stage.sv - two-entry elastic pipeline stage (main + skid register)
// Optional downstream stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_elastic_stage #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     d,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     q
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  generate
    if (WIDTH < 1 || WIDTH > 256 || CNT_WIDTH < 1) begin : g_bad_param
      $error("pipe_elastic_stage: WIDTH must be 1..256 and CNT_WIDTH >= 1");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             up_xfer;
  logic             dn_xfer;

  assign up_xfer = i_valid & ready_q;
  assign dn_xfer = valid_q & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (i_flush) begin
      state_d = S_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (up_xfer) begin
            main_d  = d;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (up_xfer && dn_xfer) begin
            main_d = d;
          end else if (dn_xfer) begin
            main_d  = NOP_VALUE;
            state_d = S_EMPTY;
          end else if (up_xfer) begin
            skid_d  = d;
            state_d = S_TWO;
          end
        end
        S_TWO: begin
          // ready is low here, so only the downstream side can move
          if (i_ready) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = '0;
        end
      endcase
    end

    valid_d = (state_d != S_EMPTY);
    ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign q       = main_q;
  assign o_valid = valid_q;
  assign o_ready = ready_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  // Saturating count of cycles the consumer refused valid data; survives flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !i_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/pipe_elastic_stage.md
PIPE_ELASTIC_STAGE -- requirements
Module: pipe_elastic_stage

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter NOP_VALUE, default {WIDTH{1'b0}}, payload driven on q while the stage holds no valid data.
REQ-003 Parameter CNT_WIDTH, default 16, stall counter width; used only when PIPE_STALL_CNT_EN is defined.
REQ-004 Port i_clk  input  1  stage clock; all state updates on the rising edge.
REQ-005 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_flush  input  1  synchronous flush; discards all held and incoming data.
REQ-007 Port i_valid  input  1  upstream data valid.
REQ-008 Port o_ready  output  1  stage can accept data; registered.
REQ-009 Port d  input  WIDTH  upstream payload.
REQ-010 Port o_valid  output  1  q holds valid data.
REQ-011 Port i_ready  input  1  downstream accepts q this cycle.
REQ-012 Port q  output  WIDTH  downstream payload; driven directly from the main register.
REQ-013 Port o_stall_cnt  output  CNT_WIDTH  downstream stall cycle count; present only when PIPE_STALL_CNT_EN is defined.

Function
REQ-014 The stage holds one main register and one skid register, and a state machine with states EMPTY, ONE and TWO.
REQ-015 Upstream transfer occurs when i_valid and o_ready are both 1; downstream transfer occurs when o_valid and i_ready are both 1.
REQ-016 o_valid is 1 in ONE and TWO and 0 in EMPTY; o_ready is 1 in EMPTY and ONE and 0 in TWO.
REQ-017 In EMPTY with an upstream transfer, the main register loads d and the state moves to ONE; otherwise the state stays EMPTY.
REQ-018 In ONE with both transfers, the main register loads d and the state stays ONE.
REQ-019 In ONE with a downstream transfer only, the state moves to EMPTY and the main register loads NOP_VALUE.
REQ-020 In ONE with an upstream transfer only, the skid register loads d and the state moves to TWO.
REQ-021 In TWO with i_ready=1, the main register loads the skid contents and the state moves to ONE; with i_ready=0 the state and both registers hold.
REQ-022 Latency: an accepted word appears on q with o_valid=1 on the first edge after acceptance.
REQ-023 Throughput is one word per cycle when i_ready is held at 1.
REQ-024 Words leave in acceptance order; no word is dropped or duplicated except on flush.
REQ-025 While o_valid=1 and i_ready=0, q and o_valid hold stable.
REQ-026 i_flush=1 takes priority over every other event: the state moves to EMPTY, the main register loads NOP_VALUE, the skid is discarded, and any same-cycle input is not stored.
REQ-027 The stall counter increments by 1 on each cycle with o_valid=1 and i_ready=0, saturates at all-ones, and is not cleared by i_flush.

Reset
REQ-028 While i_rst_n=0, asynchronously: state is EMPTY, q=NOP_VALUE, o_valid=0, o_ready=1, skid register=0, and o_stall_cnt=0.
REQ-029 Reset asserted mid-transfer discards all held data; the first edge after release behaves as EMPTY.

Configuration
REQ-030 With macro PIPE_STALL_CNT_EN defined, the stall counter and the o_stall_cnt port exist as specified in REQ-013 and REQ-027.
REQ-031 Without PIPE_STALL_CNT_EN, neither the port nor the counter logic exists; all other behaviour is identical.

Verification
REQ-032 WIDTH=32: reset, then drive i_valid=1 with d=0x11,0x22,0x33 on consecutive cycles and i_ready=1 -> q=0x11,0x22,0x33 on the following three cycles with o_valid=1, and o_ready stays 1.
REQ-033 Accept 0xA then 0xB with i_ready=0 -> state TWO, o_ready=0, q=0xA held; raise i_ready -> q=0xA then 0xB.
REQ-034 Hold state TWO and assert i_flush with i_valid=1 and d=0xC -> next cycle o_valid=0, q=NOP_VALUE, o_ready=1, and 0xC never appears on q.
REQ-035 With PIPE_STALL_CNT_EN defined and CNT_WIDTH=4: hold o_valid=1 and i_ready=0 for 20 cycles -> o_stall_cnt=15 (saturated); a flush leaves it at 15.
REQ-036 Assert i_rst_n=0 between clock edges while in state ONE -> o_valid=0 and q=NOP_VALUE immediately, without waiting for a clock edge.
REQ-037 Apply random i_valid and i_ready over 10,000 cycles with incrementing data -> the output sequence is exactly the input sequence in order, with no gaps or repeats.
